snake_game_engine: RTL

Game-state engine for the snake display path. On each movement strobe it advances the snake one cell on the 15×15 grid, detects wall and self collisions, grows the snake on apple capture and places a new apple. It drives the head, tail and apple coordinates and the 225-bit occupancy vector consumed by the pixel-level block controller. All outputs are registered.

---
 rtl/snake_pkg.sv | 48 ++++
 rtl/snake_body_ring.sv | 55 +++++
 rtl/snake_game_engine.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types, constants and helpers for the snake game engine.
package snake_pkg;

  localparam int GRID_SIZE = 15;
  localparam int MAX_LEN   = 32;
  localparam int CELLS     = GRID_SIZE * GRID_SIZE;
  localparam int PTR_W     = $clog2(MAX_LEN);

  localparam logic [3:0] GRID_MAX = 4'(GRID_SIZE - 1);

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;

  // UP decreases y (screen orientation); encoding makes opposites differ in bit 0.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PLACE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam coord_t INIT_HEAD  = '{x: 4'd7,  y: 4'd7};
  localparam coord_t INIT_MID   = '{x: 4'd6,  y: 4'd7};
  localparam coord_t INIT_TAIL  = '{x: 4'd5,  y: 4'd7};
  localparam coord_t INIT_APPLE = '{x: 4'd11, y: 4'd7};

  function automatic logic [7:0] cell_index(input coord_t c);
    return ({4'd0, c.x} * 8'd15) + {4'd0, c.y};
  endfunction

  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  localparam logic [CELLS-1:0] INIT_VEC = (CELLS'(1) << cell_index(INIT_HEAD))
                                        | (CELLS'(1) << cell_index(INIT_MID))
                                        | (CELLS'(1) << cell_index(INIT_TAIL));

endpackage

// File: rtl/snake_body_ring.sv
// Ring buffer of snake body coordinates: head pushes, tail pops, tail reads.
module snake_body_ring
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       push,
  input  logic       pop,
  input  coord_t     push_data,
  output coord_t     tail_data,
  output coord_t     tail_next,
  output logic [5:0] count
);

  coord_t           mem [MAX_LEN];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] head_inc;
  logic [PTR_W-1:0] tail_inc;

  assign head_inc  = head_ptr + 1'b1;
  assign tail_inc  = tail_ptr + 1'b1;
  assign tail_data = mem[tail_ptr];
  assign tail_next = mem[tail_inc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
      mem[0]   <= INIT_TAIL;
      mem[1]   <= INIT_MID;
      mem[2]   <= INIT_HEAD;
      head_ptr <= PTR_W'(2);
      tail_ptr <= '0;
      count    <= 6'd3;
    end else if (init) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
      mem[0]   <= INIT_TAIL;
      mem[1]   <= INIT_MID;
      mem[2]   <= INIT_HEAD;
      head_ptr <= PTR_W'(2);
      tail_ptr <= '0;
      count    <= 6'd3;
    end else begin
      if (push) begin
        mem[head_inc] <= push_data;
        head_ptr      <= head_inc;
      end
      if (pop) tail_ptr <= tail_inc;
      if (push && !pop) count <= count + 6'd1;
      else if (pop && !push) count <= count - 6'd1;
    end
  end

endmodule

// File: rtl/snake_game_engine.sv
// Snake game-state engine: movement, collisions, growth and apple placement.
module snake_game_engine
  import snake_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             mastClk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  output logic [3:0]       Head_X,
  output logic [3:0]       Head_Y,
  output logic [3:0]       Tail_X,
  output logic [3:0]       Tail_Y,
  output logic [3:0]       Apple_X,
  output logic [3:0]       Apple_Y,
  output logic [CELLS-1:0] Cell_Snake_Vector,
  output logic [5:0]       length,
  output logic [7:0]       score,
  output logic             game_over,
  output logic             won,
  output state_t           state_dbg
);

  state_t           state;
  dir_t             dir;
  dir_t             pending_dir;
  dir_t             req_dir;
  logic             req_valid;
  coord_t           head_r, tail_r, apple_r, cand, next_c;
  coord_t           ring_tail, ring_tail_next;
  logic [CELLS-1:0] vec;
  logic [7:0]       lfsr;
  logic [7:0]       next_idx, tail_idx, cand_idx;
  logic [5:0]       count;
  logic             tick_pend, in_grid, self_hit, eat, crash, step_en;
  logic             push, pop, cand_ok, reinit;

  snake_body_ring u_ring (
    .clk       (mastClk),
    .rst       (rst),
    .init      (reinit),
    .push      (push),
    .pop       (pop),
    .push_data (next_c),
    .tail_data (ring_tail),
    .tail_next (ring_tail_next),
    .count     (count)
  );

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (up)         req_dir = DIR_UP;
    else if (down)  req_dir = DIR_DOWN;
    else if (left)  req_dir = DIR_LEFT;
    else if (right) req_dir = DIR_RIGHT;
    else            req_valid = 1'b0;
  end

  // The step always moves along pending_dir as it stood before this edge.
  always_comb begin
    next_c  = head_r;
    in_grid = 1'b1;
    case (pending_dir)
      DIR_UP:   if (head_r.y == 4'd0)     in_grid = 1'b0; else next_c.y = head_r.y - 4'd1;
      DIR_DOWN: if (head_r.y == GRID_MAX) in_grid = 1'b0; else next_c.y = head_r.y + 4'd1;
      DIR_LEFT: if (head_r.x == 4'd0)     in_grid = 1'b0; else next_c.x = head_r.x - 4'd1;
      default:  if (head_r.x == GRID_MAX) in_grid = 1'b0; else next_c.x = head_r.x + 4'd1;
    endcase
  end

  assign next_idx = cell_index(next_c);
  assign tail_idx = cell_index(tail_r);
  assign cand_idx = cell_index(cand);
  // Entering the current tail cell is legal: the tail leaves on the same edge.
  assign self_hit = in_grid && vec[next_idx] && (next_c != ring_tail);
  assign eat      = in_grid && (next_c == apple_r);
  assign crash    = !in_grid || self_hit;
  assign step_en  = (state == ST_RUN) && (tick || tick_pend);
  assign push     = step_en && !crash;
  assign pop      = push && !eat;
  assign cand_ok  = (cand.x <= GRID_MAX) && (cand.y <= GRID_MAX) && !vec[cand_idx];
  assign reinit   = (state == ST_OVER) && start;

  always_ff @(posedge mastClk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge mastClk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dir         <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      head_r      <= INIT_HEAD;
      tail_r      <= INIT_TAIL;
      apple_r     <= INIT_APPLE;
      cand        <= '0;
      vec         <= INIT_VEC;
      score       <= 8'd0;
      game_over   <= 1'b0;
      won         <= 1'b0;
      tick_pend   <= 1'b0;
    end else begin
      if (req_valid && (req_dir != opposite_dir(dir))) pending_dir <= req_dir;
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN: begin
          if (step_en) begin
            tick_pend <= 1'b0;
            dir       <= pending_dir;
            if (crash) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end else if (eat) begin
              head_r        <= next_c;
              vec[next_idx] <= 1'b1;
              if (score != 8'hFF) score <= score + 8'd1;
              if (count == 6'(MAX_LEN - 1)) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
                won       <= 1'b1;
              end else begin
                state <= ST_PLACE;
                cand  <= '{x: lfsr[7:4], y: lfsr[3:0]};
              end
            end else begin
              head_r        <= next_c;
              tail_r        <= ring_tail_next;
              // Set after clear so a head entering the old tail cell keeps its bit.
              vec[tail_idx] <= 1'b0;
              vec[next_idx] <= 1'b1;
            end
          end
        end
        ST_PLACE: begin
          if (tick) tick_pend <= 1'b1;
          if (cand_ok) begin
            apple_r <= cand;
            state   <= ST_RUN;
          end else if (cand.y == 4'hF) begin
            cand.y <= 4'h0;
            cand.x <= cand.x + 4'd1;
          end else begin
            cand.y <= cand.y + 4'd1;
          end
        end
        default: begin
          if (start) begin
            state       <= ST_IDLE;
            dir         <= DIR_RIGHT;
            pending_dir <= DIR_RIGHT;
            head_r      <= INIT_HEAD;
            tail_r      <= INIT_TAIL;
            apple_r     <= INIT_APPLE;
            cand        <= '0;
            vec         <= INIT_VEC;
            score       <= 8'd0;
            game_over   <= 1'b0;
            won         <= 1'b0;
            tick_pend   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Head_X            = head_r.x;
  assign Head_Y            = head_r.y;
  assign Tail_X            = tail_r.x;
  assign Tail_Y            = tail_r.y;
  assign Apple_X           = apple_r.x;
  assign Apple_Y           = apple_r.y;
  assign Cell_Snake_Vector = vec;
  assign length            = count;
  assign state_dbg         = state;

endmodule
